// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the execute sequencer, the ALU and the datapath bus.
// The slave modport is the sequencer's view; master is the surrounding datapath/consumer.
interface alu_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 8
);
    logic                start;
    logic [OP_W-1:0]     alu_op;
    logic                start_ready;
    logic [OP_W-1:0]     alu_control;
    logic [2*DATA_W-1:0] alu_result;
    logic                z_valid;
    logic                z_ack;
    logic                op_error;
    logic [DATA_W-1:0]   z_high;
    logic [DATA_W-1:0]   z_low;
    logic                zhigh_out;
    logic                zlow_out;
    logic [DATA_W-1:0]   bus_out;

    modport slave (
        input  start, alu_op, alu_result, z_ack, zhigh_out, zlow_out,
        output start_ready, alu_control, z_valid, op_error, z_high, z_low, bus_out
    );

    modport master (
        output start, alu_op, alu_result, z_ack, zhigh_out, zlow_out,
        input  start_ready, alu_control, z_valid, op_error, z_high, z_low, bus_out
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-stage sequencer: latches the opcode for the ALU, waits its settle time and
// captures the 64-bit result into the Z registers, which it gates onto the datapath bus.
//
// state    | meaning
// S_IDLE   | ready for a new op; alu_control keeps the previous opcode
// S_SETTLE | ALU settling; counter runs down, capture on the edge where it reads zero
// S_HOLD   | Z holds a fresh result, waiting for z_ack
module alu_result_stage #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 8,
    parameter int MULDIV_WAIT = 4
) (
    input  logic                clock_i,
    input  logic                clear_i,
    alu_result_stage_if.slave   bus_if
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(8'h06);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(8'h07);
    localparam logic [OP_W-1:0] OP_MIN    = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_MAX    = OP_W'(8'h0E);
    localparam logic [3:0]      MD_CNT    = 4'(MULDIV_WAIT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [OP_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0] zh_q, zh_d;
    logic [DATA_W-1:0] zl_q, zl_d;
    logic              err_q, err_d;

    always_ff @(posedge clock_i) begin
        if (!clear_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            zh_q    <= '0;
            zl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            zh_q    <= zh_d;
            zl_q    <= zl_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        zh_d    = zh_q;
        zl_d    = zl_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    ctrl_d  = bus_if.alu_op;
                    cnt_d   = (bus_if.alu_op == OP_MUL || bus_if.alu_op == OP_DIV) ? MD_CNT : 4'd0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    // Range check uses the latched opcode, the one the ALU actually saw.
                    zh_d    = bus_if.alu_result[2*DATA_W-1:DATA_W];
                    zl_d    = bus_if.alu_result[DATA_W-1:0];
                    err_d   = (ctrl_q < OP_MIN) || (ctrl_q > OP_MAX);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (bus_if.z_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.start_ready = (state_q == S_IDLE);
    assign bus_if.z_valid     = (state_q == S_HOLD);
    assign bus_if.alu_control = ctrl_q;
    assign bus_if.op_error    = err_q;
    assign bus_if.z_high      = zh_q;
    assign bus_if.z_low       = zl_q;
    assign bus_if.bus_out     = bus_if.zhigh_out ? zh_q :
                                bus_if.zlow_out  ? zl_q : '0;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, simple and multicycle ops, busy/ack handling,
// opcode range errors, bus gating priority and reset in the middle of an op.
module tb_alu_result_stage;
    logic clk = 1'b0;
    logic clear = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.DATA_W(32), .OP_W(8)) bif ();

    alu_result_stage #(.DATA_W(32), .OP_W(8), .MULDIV_WAIT(4)) dut (
        .clock_i (clk),
        .clear_i (clear),
        .bus_if  (bif.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic simple_op(input logic [7:0] op, input logic [63:0] res,
                             input logic exp_err, input string tag);
        bif.start = 1'b1; bif.alu_op = op; bif.alu_result = res;
        tick();
        bif.start = 1'b0;
        chk({tag, "_settle_valid"}, 64'(bif.z_valid), 64'h0);
        tick();
        chk({tag, "_valid"}, 64'(bif.z_valid), 64'h1);
        chk({tag, "_err"}, 64'(bif.op_error), 64'(exp_err));
        chk({tag, "_zlow"}, 64'(bif.z_low), 64'(res[31:0]));
        chk({tag, "_zhigh"}, 64'(bif.z_high), 64'(res[63:32]));
        bif.z_ack = 1'b1;
        tick();
        bif.z_ack = 1'b0;
        chk({tag, "_ready"}, 64'(bif.start_ready), 64'h1);
    endtask

    initial begin
        bif.start = 1'b0; bif.alu_op = 8'h00; bif.alu_result = 64'h0;
        bif.z_ack = 1'b0; bif.zhigh_out = 1'b0; bif.zlow_out = 1'b0;

        // Reset
        tick();
        chk("rst_ready", 64'(bif.start_ready), 64'h1);
        chk("rst_valid", 64'(bif.z_valid), 64'h0);
        chk("rst_ctrl", 64'(bif.alu_control), 64'h0);
        chk("rst_zhigh", 64'(bif.z_high), 64'h0);
        chk("rst_zlow", 64'(bif.z_low), 64'h0);
        chk("rst_err", 64'(bif.op_error), 64'h0);
        chk("rst_bus", 64'(bif.bus_out), 64'h0);
        clear = 1'b1;
        tick();

        // ADD, single-cycle settle
        bif.start = 1'b1; bif.alu_op = 8'h04; bif.alu_result = 64'h0000_0000_0000_0007;
        tick();
        bif.start = 1'b0;
        chk("add_ctrl", 64'(bif.alu_control), 64'h04);
        chk("add_busy", 64'(bif.start_ready), 64'h0);
        chk("add_e0_valid", 64'(bif.z_valid), 64'h0);
        tick();
        chk("add_valid", 64'(bif.z_valid), 64'h1);
        chk("add_zlow", 64'(bif.z_low), 64'h7);
        chk("add_zhigh", 64'(bif.z_high), 64'h0);
        chk("add_err", 64'(bif.op_error), 64'h0);
        bif.z_ack = 1'b1;
        tick();
        bif.z_ack = 1'b0;
        chk("add_ack_valid", 64'(bif.z_valid), 64'h0);
        chk("add_ack_ready", 64'(bif.start_ready), 64'h1);
        chk("add_retain", 64'(bif.z_low), 64'h7);

        // MUL, four-cycle settle, with a competing start while busy
        bif.start = 1'b1; bif.alu_op = 8'h06; bif.alu_result = 64'h0000_0001_FFFF_FFFE;
        tick();
        bif.alu_op = 8'h05;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("mul_wait%0d_valid", i), 64'(bif.z_valid), 64'h0);
            chk($sformatf("mul_wait%0d_ctrl", i), 64'(bif.alu_control), 64'h06);
        end
        tick();
        chk("mul_valid", 64'(bif.z_valid), 64'h1);
        chk("mul_zhigh", 64'(bif.z_high), 64'h1);
        chk("mul_zlow", 64'(bif.z_low), 64'hFFFF_FFFE);
        chk("mul_ctrl_hold", 64'(bif.alu_control), 64'h06);
        bif.zhigh_out = 1'b1;
        #1 chk("bus_zhigh", 64'(bif.bus_out), 64'h1);
        bif.zlow_out = 1'b1;
        #1 chk("bus_both", 64'(bif.bus_out), 64'h1);
        bif.zhigh_out = 1'b0;
        #1 chk("bus_zlow", 64'(bif.bus_out), 64'hFFFF_FFFE);
        bif.zlow_out = 1'b0;
        #1 chk("bus_none", 64'(bif.bus_out), 64'h0);

        // Late ack: Z and z_valid must hold while the ALU output wanders
        bif.alu_result = 64'h0000_DEAD_0000_BEEF;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("hold%0d_valid", i), 64'(bif.z_valid), 64'h1);
            chk($sformatf("hold%0d_zlow", i), 64'(bif.z_low), 64'hFFFF_FFFE);
            chk($sformatf("hold%0d_ctrl", i), 64'(bif.alu_control), 64'h06);
        end
        bif.start = 1'b0;
        bif.z_ack = 1'b1;
        tick();
        bif.z_ack = 1'b0;
        chk("late_ack_ready", 64'(bif.start_ready), 64'h1);
        chk("late_ack_valid", 64'(bif.z_valid), 64'h0);
        chk("late_ack_zhigh", 64'(bif.z_high), 64'h1);
        chk("late_ack_ctrl", 64'(bif.alu_control), 64'h06);

        // Opcode range boundaries
        simple_op(8'hFF, 64'h0000_0000_0000_0001, 1'b1, "inv_ff");
        simple_op(8'h02, 64'h0000_0005_0000_0003, 1'b0, "op02");
        simple_op(8'h01, 64'h0000_0000_0000_0011, 1'b1, "op01");
        simple_op(8'h0E, 64'h0000_0022_0000_0033, 1'b0, "op0e");
        simple_op(8'h0F, 64'h0000_0044_0000_0055, 1'b1, "op0f");
        chk("err_sticky", 64'(bif.op_error), 64'h1);

        // Reset while a DIV is settling
        bif.start = 1'b1; bif.alu_op = 8'h07; bif.alu_result = 64'hAAAA_AAAA_5555_5555;
        tick();
        bif.start = 1'b0;
        tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
        chk("mrst_ready", 64'(bif.start_ready), 64'h1);
        chk("mrst_valid", 64'(bif.z_valid), 64'h0);
        chk("mrst_zhigh", 64'(bif.z_high), 64'h0);
        chk("mrst_zlow", 64'(bif.z_low), 64'h0);
        chk("mrst_ctrl", 64'(bif.alu_control), 64'h0);
        chk("mrst_err", 64'(bif.op_error), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("mrst_quiet%0d", i), 64'(bif.z_valid), 64'h0);
        end
        simple_op(8'h04, 64'h0000_0000_0000_0009, 1'b0, "post_rst_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
